// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: the canonical NOP, fetch fault codes
// and the fetch-stage state encoding.
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter for the fetch stage: PC register, next-PC selection
// (redirect / PC+4 / hold) and classification of the current PC.
module pc_unit
    import rv32_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_SIZE   = 512,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output fault_t                fault
);

    localparam int                IDX_W     = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0]  MEM_LIMIT = IDX_W'(MEM_SIZE);

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [ADDR_WIDTH-1:0] pc_plus4_s;
    fault_t                fault_s;

    // Sequential PC; wraps silently at the top of the address space.
    always_comb begin
        pc_plus4_s = pc_r + ADDR_WIDTH'(4);
    end

    // Misalignment is checked before range so a bad low pair always reports 01.
    always_comb begin
        fault_s = FAULT_NONE;
        if (pc_r[1:0] != 2'b00) begin
            fault_s = FAULT_MISALIGN;
        end else if (pc_r[ADDR_WIDTH-1:2] >= MEM_LIMIT) begin
            fault_s = FAULT_RANGE;
        end else begin
            fault_s = FAULT_NONE;
        end
    end

    // Next-PC selection: redirect overrides sequential advance.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect_valid) begin
            pc_next_s = redirect_pc;
        end else if (advance) begin
            pc_next_s = pc_plus4_s;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc       = pc_r;
    assign pc_plus4 = pc_plus4_s;
    assign fault    = fault_s;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: drives the instruction memory from the PC and
// captures the returned word into the IF/ID register behind a valid/ready port.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_SIZE   = 512,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_plus4,
    output logic [1:0]            out_fault
);

    localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(NOP_INSTR);

    fetch_state_t          state_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_instr_r;
    logic [ADDR_WIDTH-1:0] out_pc_r;
    logic [ADDR_WIDTH-1:0] out_pc_plus4_r;
    fault_t                out_fault_r;

    logic                  load_s;
    logic                  advance_s;
    logic [ADDR_WIDTH-1:0] pc_s;
    logic [ADDR_WIDTH-1:0] pc_plus4_s;
    fault_t                fault_s;

    pc_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .RESET_PC   (RESET_PC)
    ) u_pc_unit (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance_s),
        .pc             (pc_s),
        .pc_plus4       (pc_plus4_s),
        .fault          (fault_s)
    );

    // IF/ID may be overwritten when empty or when decode takes it this cycle.
    always_comb begin
        load_s = !out_valid_r || out_ready;
    end

    // PC steps only on a clean fetch; a faulting PC stays put for diagnosis.
    always_comb begin
        advance_s = 1'b0;
        if (!redirect_valid && load_s && (state_r == RUN) && (fault_s == FAULT_NONE)) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
    end

    // IF/ID register and fetch state: redirect, then load, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= RUN;
            out_valid_r    <= 1'b0;
            out_instr_r    <= NOP_WORD;
            out_pc_r       <= {ADDR_WIDTH{1'b0}};
            out_pc_plus4_r <= {ADDR_WIDTH{1'b0}};
            out_fault_r    <= FAULT_NONE;
        end else if (redirect_valid) begin
            state_r     <= RUN;
            out_valid_r <= 1'b0;
            out_instr_r <= NOP_WORD;
            out_fault_r <= FAULT_NONE;
        end else if (load_s) begin
            case (state_r)
                RUN: begin
                    out_valid_r    <= 1'b1;
                    out_pc_r       <= pc_s;
                    out_pc_plus4_r <= pc_plus4_s;
                    if (fault_s != FAULT_NONE) begin
                        out_instr_r <= NOP_WORD;
                        out_fault_r <= fault_s;
                        state_r     <= HALT;
                    end else begin
                        out_instr_r <= instr;
                        out_fault_r <= FAULT_NONE;
                        state_r     <= RUN;
                    end
                end
                HALT: begin
                    out_valid_r <= 1'b0;
                    out_instr_r <= NOP_WORD;
                    out_fault_r <= FAULT_NONE;
                    state_r     <= HALT;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    out_instr_r <= NOP_WORD;
                    out_fault_r <= FAULT_NONE;
                    state_r     <= RUN;
                end
            endcase
        end
    end

    assign instr_addr   = pc_s;
    assign out_valid    = out_valid_r;
    assign out_instr    = out_instr_r;
    assign out_pc       = out_pc_r;
    assign out_pc_plus4 = out_pc_plus4_r;
    assign out_fault    = out_fault_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural instruction memory, a
// scoreboard of expected IF/ID entries, and one task per scenario.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [1:0]  fault;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [1:0]  out_fault;

    logic [31:0] mem [0:511];
    exp_t        sb[$];
    int          checks;
    int          errors;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_SIZE   (512),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_addr     (instr_addr),
        .instr          (instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr = (instr_addr[31:2] < 30'd512) ? mem[instr_addr[10:2]] : 32'hDEAD_BEEF;

    function automatic exp_t mk(input logic [31:0] pc, input logic [1:0] f);
        exp_t e;
        e.instr = (f != 2'b00) ? NOP : mem[pc[10:2]];
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.fault = f;
        return e;
    endfunction

    // Scoreboard: every accepted IF/ID entry must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no entry", out_pc, out_instr);
            end else begin
                e = sb.pop_front();
                if ({out_instr, out_pc, out_pc_plus4, out_fault} !== {e.instr, e.pc, e.pc4, e.fault}) begin
                    errors++;
                    $display("FAIL sb_entry: got instr=%h pc=%h pc4=%h fault=%b, expected instr=%h pc=%h pc4=%h fault=%b",
                             out_instr, out_pc, out_pc_plus4, out_fault, e.instr, e.pc, e.pc4, e.fault);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (instr_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", instr_addr); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h expected %h", out_instr, NOP); end
        checks++; if ({out_pc, out_pc_plus4} !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h/%h expected 0/0", out_pc, out_pc_plus4); end
        checks++; if (out_fault !== 2'b00) begin errors++; $display("FAIL rst_fault: got %b expected 00", out_fault); end
        for (int i = 0; i < 4; i++) sb.push_back(mk(32'(i * 4), 2'b00));
        rst_n = 1'b1; out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", out_valid); end
        cyc(); cyc(); cyc();
        checks++; if (instr_addr !== 32'h10) begin errors++; $display("FAIL stream_addr: got %h expected 10", instr_addr); end
        cyc();
        out_ready = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b1;
        sb.push_back(mk(32'h0, 2'b00));
        cyc();
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({out_valid, out_instr, out_pc, instr_addr} !== {1'b1, mem[1], 32'h4, 32'h8}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b instr=%h pc=%h addr=%h expected v=1 instr=%h pc=4 addr=8",
                         i, out_valid, out_instr, out_pc, instr_addr, mem[1]);
            end
        end
        sb.push_back(mk(32'h4, 2'b00));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        checks++; if ({out_instr, out_pc} !== {mem[2], 32'h8}) begin errors++; $display("FAIL stall_release: got %h@%h expected %h@8", out_instr, out_pc, mem[2]); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cyc();
        checks++; if ({out_valid, instr_addr} !== {1'b0, 32'h40}) begin errors++; $display("FAIL redir_bubble: got v=%b addr=%h expected v=0 addr=40", out_valid, instr_addr); end
        redirect_valid = 1'b0; out_ready = 1'b1;
        sb.push_back(mk(32'h40, 2'b00));
        cyc();
        checks++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h40, mem[16]}) begin errors++; $display("FAIL redir_target: got v=%b pc=%h instr=%h expected v=1 pc=40 instr=%h", out_valid, out_pc, out_instr, mem[16]); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        cyc();
        redirect_valid = 1'b0;
        sb.push_back(mk(32'h42, 2'b01));
        cyc();
        checks++; if ({out_valid, out_fault, out_instr, out_pc} !== {1'b1, 2'b01, NOP, 32'h42}) begin errors++; $display("FAIL mis_entry: got v=%b f=%b instr=%h pc=%h expected v=1 f=01 instr=%h pc=42", out_valid, out_fault, out_instr, out_pc, NOP); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if ({out_valid, instr_addr} !== {1'b0, 32'h42}) begin errors++; $display("FAIL mis_halt%0d: got v=%b addr=%h expected v=0 addr=42", i, out_valid, instr_addr); end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        cyc();
        redirect_valid = 1'b0;
        sb.push_back(mk(32'h10, 2'b00));
        cyc();
        checks++; if ({out_valid, out_pc, out_fault} !== {1'b1, 32'h10, 2'b00}) begin errors++; $display("FAIL mis_resume: got v=%b pc=%h f=%b expected v=1 pc=10 f=00", out_valid, out_pc, out_fault); end
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_range();
        redirect_valid = 1'b1; redirect_pc = 32'h7F8;
        cyc();
        redirect_valid = 1'b0; out_ready = 1'b1;
        sb.push_back(mk(32'h7F8, 2'b00));
        sb.push_back(mk(32'h7FC, 2'b00));
        sb.push_back(mk(32'h800, 2'b10));
        cyc(); cyc();
        checks++; if ({out_pc, out_fault, out_instr} !== {32'h7FC, 2'b00, mem[511]}) begin errors++; $display("FAIL range_last: got pc=%h f=%b instr=%h expected pc=7fc f=00 instr=%h", out_pc, out_fault, out_instr, mem[511]); end
        cyc();
        checks++; if ({out_valid, out_fault, out_pc} !== {1'b1, 2'b10, 32'h800}) begin errors++; $display("FAIL range_fault: got v=%b f=%b pc=%h expected v=1 f=10 pc=800", out_valid, out_fault, out_pc); end
        cyc(); cyc();
        checks++; if ({out_valid, instr_addr} !== {1'b0, 32'h800}) begin errors++; $display("FAIL range_halt: got v=%b addr=%h expected v=0 addr=800", out_valid, instr_addr); end
    endtask

    task automatic test_async_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        cyc();
        redirect_valid = 1'b0; out_ready = 1'b1;
        sb.push_back(mk(32'h20, 2'b00));
        cyc(); cyc();
        out_ready = 1'b0;
        cyc();
        checks++; if ({out_valid, out_pc} !== {1'b1, 32'h24}) begin errors++; $display("FAIL ar_stall: got v=%b pc=%h expected v=1 pc=24", out_valid, out_pc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, instr_addr, out_instr} !== {1'b0, 32'h0, NOP}) begin errors++; $display("FAIL ar_clear: got v=%b addr=%h instr=%h expected v=0 addr=0 instr=%h", out_valid, instr_addr, out_instr, NOP); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
        test_reset();
        test_stall();
        test_redirect();
        test_misalign();
        test_range();
        test_async_reset();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion, expected finish before 20000");
        $fatal(1);
    end

endmodule
